keypad_scan_ctrl: RTL and testbench

Sequential scanner that drives the keypad column lines one-hot and samples the returned row lines. It sits directly upstream of the keypad matrix model: its col output feeds the matrix, and it consumes the matrix's row output. Each full sweep of four columns is reduced to a single key decision, which is then debounced. The block emits a 4-bit key code with a one-cycle valid pulse per debounced press and holds a pressed-status flag until release.

---
 rtl/keypad_scan_ctrl.sv | 118 +++++++++++
 tb/tb_keypad_scan_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: one-hot column scanner with per-sweep key decision and press/release debounce
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   row[3:0]   row returns for the currently driven column
//   col[3:0]   one-hot active-high column drive
//   key_code   debounced key index, 4*row + column
//   key_valid  one-cycle pulse when a press is accepted
//   key_held   high from acceptance until debounced release
module keypad_scan_ctrl #(
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int SW = $clog2(SETTLE_CYC);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DB = CW'(DEBOUNCE_CNT);

    typedef enum logic {RELEASED, PRESSED} state_t;

    state_t        state, state_n;
    logic [SW-1:0] set_cnt;
    logic [1:0]    acc_hits, row_hits, sw_hits, c_idx, row_r;
    logic [2:0]    row_cnt, hit_sum;
    logic [3:0]    acc_idx, sw_idx, prev_idx, prev_idx_n, code_n;
    logic          prev_hit, prev_hit_n, valid_n, held_n;
    logic [CW-1:0] stab_cnt, stab_n, rel_cnt, rel_n;
    logic          sample, eval, is_key, is_none;

    // Sweep result includes the sample taken on the evaluation edge itself
    always_comb begin
        sample   = set_cnt == SET_MAX;
        eval     = sample && col[3];
        c_idx    = col[1] ? 2'd1 : col[2] ? 2'd2 : col[3] ? 2'd3 : 2'd0;
        row_cnt  = {2'b0, row[0]} + {2'b0, row[1]} + {2'b0, row[2]} + {2'b0, row[3]};
        row_hits = row_cnt >= 3'd2 ? 2'd2 : row_cnt[1:0];
        hit_sum  = {1'b0, acc_hits} + {1'b0, row_hits};
        sw_hits  = hit_sum >= 3'd2 ? 2'd2 : hit_sum[1:0];
        row_r    = row[3] ? 2'd3 : row[2] ? 2'd2 : row[1] ? 2'd1 : 2'd0;
        sw_idx   = |row ? {row_r, c_idx} : acc_idx;
        is_key   = sw_hits == 2'd1;
        is_none  = sw_hits == 2'd0;
    end

    always_comb begin
        state_n    = state;
        stab_n     = stab_cnt;
        rel_n      = rel_cnt;
        code_n     = key_code;
        valid_n    = 1'b0;
        held_n     = key_held;
        prev_hit_n = prev_hit;
        prev_idx_n = prev_idx;
        if (eval) begin
            prev_hit_n = is_key;
            prev_idx_n = sw_idx;
            if (state == RELEASED) begin
                stab_n = !is_key ? '0 :
                         (prev_hit && prev_idx == sw_idx) ? (stab_cnt == DB ? DB : stab_cnt + 1'b1) :
                         CW'(1);
                if (is_key && stab_n == DB) begin
                    state_n = PRESSED;
                    code_n  = sw_idx;
                    valid_n = 1'b1;
                    held_n  = 1'b1;
                    rel_n   = '0;
                end
            end else begin
                // MULTI and any KEY both restart the release count
                rel_n = is_none ? (rel_cnt == DB ? DB : rel_cnt + 1'b1) : '0;
                if (is_none && rel_n == DB) begin
                    state_n = RELEASED;
                    held_n  = 1'b0;
                    stab_n  = '0;
                    rel_n   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RELEASED;
            set_cnt   <= '0;
            col       <= 4'b0001;
            acc_hits  <= '0;
            acc_idx   <= '0;
            prev_hit  <= 1'b0;
            prev_idx  <= '0;
            stab_cnt  <= '0;
            rel_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            set_cnt   <= sample ? '0 : set_cnt + 1'b1;
            col       <= sample ? {col[2:0], col[3]} : col;
            acc_hits  <= eval ? '0 : sample ? sw_hits : acc_hits;
            acc_idx   <= eval ? '0 : sample ? sw_idx : acc_idx;
            prev_hit  <= prev_hit_n;
            prev_idx  <= prev_idx_n;
            stab_cnt  <= stab_n;
            rel_cnt   <= rel_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: table-driven bench for keypad_scan_ctrl with a behavioural key matrix
module tb_keypad_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_held;
    logic [15:0] keys = '0;
    int          pulses = 0;
    int          passed = 0;
    int          total = 0;

    typedef struct {
        logic [15:0] k;
        int          sweeps;
        int          exp_pulses;
        logic        exp_held;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t vecs[$];

    keypad_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    always_comb
        for (int r = 0; r < 4; r++) row[r] = |(keys[4*r +: 4] & col);

    always @(negedge clk) if (key_valid) pulses++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input vec_t v, input int n);
        int p0;
        p0   = pulses;
        keys = v.k;
        repeat (16 * v.sweeps) @(posedge clk);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_pulses", n), pulses - p0, v.exp_pulses);
        chk($sformatf("v%0d_held", n), int'(key_held), int'(v.exp_held));
        chk($sformatf("v%0d_code", n), int'(key_code), int'(v.exp_code));
    endtask

    initial begin
        vec_t h;
        vecs = '{
            '{16'h0000, 9, 0, 1'b0, 4'd0},
            '{16'h0200, 3, 1, 1'b1, 4'd9},
            '{16'h0200, 2, 0, 1'b1, 4'd9},
            '{16'h0000, 2, 0, 1'b1, 4'd9},
            '{16'h0000, 1, 0, 1'b0, 4'd9},
            '{16'h0060, 5, 0, 1'b0, 4'd9},
            '{16'h0020, 2, 0, 1'b0, 4'd9},
            '{16'h0020, 1, 1, 1'b1, 4'd5},
            '{16'h0000, 3, 0, 1'b0, 4'd5},
            '{16'h0004, 1, 0, 1'b0, 4'd5},
            '{16'h0000, 1, 0, 1'b0, 4'd5},
            '{16'h0004, 1, 0, 1'b0, 4'd5},
            '{16'h0000, 1, 0, 1'b0, 4'd5},
            '{16'h0004, 1, 0, 1'b0, 4'd5},
            '{16'h0000, 1, 0, 1'b0, 4'd5},
            '{16'h0004, 2, 0, 1'b0, 4'd5},
            '{16'h0004, 1, 1, 1'b1, 4'd2},
            '{16'h0000, 3, 0, 1'b0, 4'd2},
            '{16'h0002, 3, 1, 1'b1, 4'd1},
            '{16'h0000, 2, 0, 1'b1, 4'd1},
            '{16'h0006, 1, 0, 1'b1, 4'd1},
            '{16'h0000, 2, 0, 1'b1, 4'd1},
            '{16'h0000, 1, 0, 1'b0, 4'd1},
            '{16'h0008, 3, 1, 1'b1, 4'd3},
            '{16'h0080, 4, 0, 1'b1, 4'd3},
            '{16'h0000, 3, 0, 1'b0, 4'd3}
        };
        repeat (3) @(negedge clk);
        #1;
        chk("rst_col", int'(col), 1);
        chk("rst_code", int'(key_code), 0);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held", int'(key_held), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("col_c%0d", k), int'(col), 1 << ((k / 4) % 4));
        end
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);
        h = '{16'h8000, 3, 1, 1'b1, 4'd15};
        step(h, 100);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_col", int'(col), 2);
        rst_n = 1'b0;
        #1;
        chk("async_col", int'(col), 1);
        chk("async_held", int'(key_held), 0);
        chk("async_code", int'(key_code), 0);
        chk("async_valid", int'(key_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        h = '{16'h8000, 2, 0, 1'b0, 4'd0};
        step(h, 101);
        h = '{16'h8000, 1, 1, 1'b1, 4'd15};
        step(h, 102);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
